// File: rtl/pkt_framer_pkg.sv
// Shared types and defaults for the packet framer: FSM state encoding,
// default payload width / inter-frame gap and the length legality check.
package pkt_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DW_DEFAULT  = 16;
  localparam int IFG_DEFAULT = 2;

  function automatic logic len_ok(input int len, input int dw);
    return (len >= 1) && (len <= dw);
  endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Inter-frame gap down-counter: load arms it for IFG cycles, done flags the
// final gap cycle so the framer can return to IDLE on that edge.
module pkt_gap_timer
  import pkt_framer_pkg::*;
#(
  parameter int IFG = IFG_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 4'(IFG - 1);
    end else if (count && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/pkt_framer.sv
// Serialises one payload word per frame, LSB first, with a start pulse,
// last-bit marker and a fixed idle gap; illegal lengths are dropped with len_err.
module pkt_framer
  import pkt_framer_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int IFG = IFG_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic [$clog2(DW):0]   in_len,
  input  logic                  in_sof,
  output logic                  pkt_data_vld,
  output logic                  first,
  output logic                  sdo,
  output logic                  lastbit,
  output logic                  len_err
);

  localparam int LW = $clog2(DW) + 1;
  localparam logic [LW:0] IDX_ONE = (LW + 1)'(1);
  localparam logic [LW:0] IDX_TWO = (LW + 1)'(2);

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            vld_q, vld_d;
  logic            first_q, first_d;
  logic            sdo_q, sdo_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            gap_load, gap_count, gap_done;

  pkt_gap_timer #(.IFG(IFG)) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gap_load),
    .count (gap_count),
    .done  (gap_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    shreg_d   = shreg_q;
    vld_d     = 1'b0;
    first_d   = 1'b0;
    sdo_d     = 1'b0;
    last_d    = 1'b0;
    err_d     = 1'b0;
    gap_load  = 1'b0;
    gap_count = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (len_ok(int'(in_len), DW)) begin
            state_d = ST_SHIFT;
            shreg_d = in_data >> 1;
            len_d   = in_len;
            cnt_d   = '0;
            vld_d   = 1'b1;
            first_d = in_sof;
            sdo_d   = in_data[0];
            last_d  = (in_len == LW'(1));
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (last_q) begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
          cnt_d    = '0;
        end else begin
          // cnt_q indexes the bit now on sdo; the next bit is last when cnt_q+2 == len
          cnt_d   = cnt_q + LW'(1);
          sdo_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          last_d  = (({1'b0, cnt_q} + IDX_TWO) == {1'b0, len_q});
        end
      end
      ST_GAP: begin
        gap_count = 1'b1;
        if (gap_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      sdo_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      sdo_q   <= sdo_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Payload holding registers carry no reset; they are reloaded on every transfer
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    len_q   <= len_d;
  end

  assign in_ready     = rst_n && (state_q == ST_IDLE);
  assign pkt_data_vld = vld_q;
  assign first        = first_q;
  assign sdo          = sdo_q;
  assign lastbit      = last_q;
  assign len_err      = err_q;

  // Reference IDX_ONE so the index width helper stays tied to the counter width
  logic unused_idx;
  assign unused_idx = IDX_ONE[0];

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 Parameter DW, default 16, payload word width in bits (legal 2..32).
REQ-002 Parameter IFG, default 2, minimum idle cycles between packets (legal 1..15).
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  framer can accept a word.
REQ-007 in_data  input  DW  payload word, transmitted LSB first.
REQ-008 in_len  input  $clog2(DW)+1  payload length in bits, legal 1..DW.
REQ-009 in_sof  input  1  word opens a new frame; carried to output "first".
REQ-010 pkt_data_vld  output  1  one-cycle pulse marking the first serial bit of a packet.
REQ-011 first  output  1  asserted with pkt_data_vld when the accepted word had in_sof=1.
REQ-012 sdo  output  1  serial data bit, valid while busy.
REQ-013 lastbit  output  1  asserted for exactly the cycle carrying the final bit.
REQ-014 len_err  output  1  one-cycle pulse when a word with illegal in_len is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-016 in_ready SHALL be 1 only in IDLE; a transfer occurs on a posedge with in_valid && in_ready.
REQ-017 On a legal transfer: capture in_data, in_len, in_sof; go IDLE->SHIFT.
REQ-018 In the first SHIFT cycle (registered, one cycle after the transfer edge): pkt_data_vld=1, sdo=in_data[0], first=captured in_sof.
REQ-019 Each subsequent SHIFT cycle SHALL output the next higher bit; pkt_data_vld and first SHALL be 0.
REQ-020 lastbit SHALL be 1 in the cycle of bit in_len-1; next state GAP.
REQ-021 in_len=1: pkt_data_vld, lastbit and (if in_sof) first SHALL all be 1 in the same single cycle.
REQ-022 in_len=DW: exactly DW SHIFT cycles; bit counter SHALL not wrap or overflow.
REQ-023 GAP SHALL last exactly IFG cycles with sdo, pkt_data_vld, first and lastbit all 0, then return to IDLE.
REQ-024 Illegal in_len (0 or >DW): word consumed, no SHIFT; len_err=1 the cycle after the transfer edge; state stays IDLE.
REQ-025 sdo SHALL be 0 whenever not in SHIFT.
REQ-026 Minimum spacing between consecutive pkt_data_vld pulses SHALL be in_len+IFG+1 cycles.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs except in_ready, which is decoded from state.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counters 0 and all outputs 0 except in_ready=0 during reset.
REQ-029 Reset asserted mid-packet SHALL abort the packet with no lastbit; after release in_ready=1 on the first clock.

Structure
REQ-030 The state enum (IDLE/SHIFT/GAP) and default DW/IFG constants SHALL live in shared package pkt_framer_pkg.
REQ-031 The GAP down-counter SHALL be a sub-module pkt_gap_timer (load, count, done); shifting and FSM stay in pkt_framer.

Verification
REQ-032 Word 16'hA5C3, len=16, sof=1 -> pkt_data_vld+first on cycle 1, sdo=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, lastbit on cycle 16, in_ready back after 2 GAP cycles.
REQ-033 len=1, data=1, sof=0 -> pkt_data_vld=1, lastbit=1, sdo=1, first=0 in one cycle.
REQ-034 Back-to-back valid words len=4 -> second pkt_data_vld exactly 4+2+1=7 cycles after the first.
REQ-035 len=0 word -> len_err pulse, no pkt_data_vld, in_ready stays 1.
REQ-036 rst_n low at bit 5 of a len=12 packet -> outputs 0 immediately, no lastbit, next word framed normally.
